rr_arb_4: RTL and testbench

Four-requester round-robin arbiter that shares one resource among four clients and produces a one-hot grant. The registered 2-bit grant index drives the team's 2-to-4 decoder to form the one-hot `gnt` vector. A grant is held until the owner drops its request, or optionally until a hold-time limit expires. It sits between client request lines and the shared datapath select.

---
 rtl/rr_arb_pkg.sv | 35 +++
 rtl/dec_2to4.sv | 10 +
 rtl/rr_arb_4.sv | 118 +++++++++++
 tb/tb_rr_arb_4.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
// Provides the state encoding and the rotating-priority winner search.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_win_t;

    // Scan from the highest offset down so the lowest offset from start wins.
    function automatic rr_win_t next_winner(input logic [NUM_REQ-1:0] req,
                                            input logic [IDX_W-1:0]   start,
                                            input logic [NUM_REQ-1:0] excl);
        rr_win_t          w;
        logic [IDX_W-1:0] cand;
        w = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = start + IDX_W'(i);
            if (req[cand] && !excl[cand]) begin
                w.found = 1'b1;
                w.idx   = cand;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dec_2to4.sv
// Plain 2-to-4 one-hot decoder.
// Output bit s is set, all others clear.
module dec_2to4 (
    input  logic [1:0] s,
    output logic [3:0] y
);

    assign y = 4'b0001 << s;

endmodule

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with one-hot grant and no-bubble handoff.
// Define RR_ARB_TIMEOUT_EN to build the hold counter and forced handoff after HOLD_MAX cycles.
module rr_arb_4
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    rr_state_t          state_q, state_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] own_mask;
    logic [NUM_REQ-1:0] dec_y;
    logic               release_k;
    logic               handoff;
    rr_win_t            win;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_hold_max;
    assign unused_hold_max = 32'(HOLD_MAX);
`endif

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        own_mask  = NUM_REQ'(1) << gnt_idx_q;
        release_k = !req[gnt_idx_q];
        handoff   = release_k;

        // While granted, the owner is excluded so it can never re-win on its own handoff.
        if (state_q == IDLE) begin
            win = next_winner(req, ptr_q, '0);
        end else begin
            win = next_winner(req, gnt_idx_q + IDX_W'(1), own_mask);
        end

`ifdef RR_ARB_TIMEOUT_EN
        if (state_q == GRANT && !release_k && win.found &&
            cnt_q >= CNT_W'(HOLD_MAX - 1)) begin
            handoff = 1'b1;
        end
`endif

        case (state_q)
            IDLE: begin
                if (win.found) begin
                    gnt_idx_d = win.idx;
                    state_d   = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                if (handoff) begin
                    ptr_d = gnt_idx_q + IDX_W'(1);
                    if (win.found) begin
                        gnt_idx_d = win.idx;
`ifdef RR_ARB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    if (cnt_q != CNT_W'(HOLD_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    dec_2to4 u_dec (
        .s (gnt_idx_q),
        .y (dec_y)
    );

    assign gnt_vld = (state_q == GRANT);
    assign gnt_idx = gnt_idx_q;
    assign gnt     = dec_y & {NUM_REQ{gnt_vld}};

endmodule

// File: tb/tb_rr_arb_4.sv
// Self-checking bench for rr_arb_4: cycle-level reference model plus directed literal checks.
// Honours RR_ARB_TIMEOUT_EN with HOLD_MAX = 4.
module tb_rr_arb_4;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;

    rr_arb_4 #(.HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always #5 clk = ~clk;

    // Model state: owner < 0 means nobody holds the resource; owned counts cycles held so far.
    typedef struct packed {
        int ptr;
        int owner;
        int idx;
        int owned;
    } mstate_t;

    mstate_t m = '{ptr: 0, owner: -1, idx: 0, owned: 0};

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    chk_on  = 1'b0;
    bit    lit_pending = 1'b0;
    logic [6:0] lit_exp;
    string lit_name;

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int off = 0; off < 4; off++) begin
            int c;
            c = (start + off) % 4;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic r_rst, input logic [3:0] r);
        mstate_t n;
        int      cand;
        bit      leave;
        n = s;
        if (r_rst) begin
            n = '{ptr: 0, owner: -1, idx: 0, owned: 0};
        end else if (s.owner < 0) begin
            cand = pick(r, s.ptr, -1);
            if (cand >= 0) begin
                n.owner = cand;
                n.idx   = cand;
                n.owned = 1;
            end
        end else begin
            leave = !r[s.owner];
`ifdef RR_ARB_TIMEOUT_EN
            if (s.owned >= HM && pick(r, (s.owner + 1) % 4, s.owner) >= 0) leave = 1'b1;
`endif
            if (leave) begin
                n.ptr   = (s.owner + 1) % 4;
                cand    = pick(r, n.ptr, s.owner);
                n.owner = cand;
                if (cand >= 0) begin
                    n.idx   = cand;
                    n.owned = 1;
                end
            end else begin
                n.owned = s.owned + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst, req);
    end

    // Single compare process: model check every cycle, plus any pending literal expectation.
    always @(negedge clk) begin
        logic [6:0] act;
        logic [6:0] exp_m;
        act = {gnt_vld, gnt_idx, gnt};
        if (chk_on) begin
            exp_m[6]   = (m.owner >= 0);
            exp_m[5:4] = 2'(m.idx);
            exp_m[3:0] = (m.owner >= 0) ? (4'b0001 << m.idx) : 4'b0000;
            n_tests++;
            if (act !== exp_m) begin
                n_fail++;
                $display("FAIL model t=%0t vld_idx_gnt actual=%b required=%b", $time, act, exp_m);
            end
        end
        if (lit_pending) begin
            n_tests++;
            if (act !== lit_exp) begin
                n_fail++;
                $display("FAIL %s vld_idx_gnt actual=%b required=%b", lit_name, act, lit_exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string nm, input logic [6:0] e);
        lit_name    = nm;
        lit_exp     = e;
        lit_pending = 1'b1;
        @(negedge clk);
        #1 lit_pending = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        step(2);
        chk_on = 1'b1;
        expect_lit("reset_state", 7'b0_00_0000);
        rst = 1'b0;

        // Two requesters, owner release hands over with no bubble
        req = 4'b0101; step(1); expect_lit("first_grant", 7'b1_00_0001);
        req = 4'b0100; step(1); expect_lit("no_bubble", 7'b1_10_0100);
        req = 4'b0000; step(1); expect_lit("release_idle", 7'b0_10_0000);

        // Fairness with all four requesting, pointer wraps 3 -> 0
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b1111; step(1); expect_lit("fair_0", 7'b1_00_0001);
        step(1);
        req = 4'b1110; step(1); expect_lit("fair_1", 7'b1_01_0010);
        req = 4'b1111; step(1);
        req = 4'b1101; step(1); expect_lit("fair_2", 7'b1_10_0100);
        req = 4'b1111; step(1);
        req = 4'b1011; step(1); expect_lit("fair_3", 7'b1_11_1000);
        req = 4'b1111; step(1);
        req = 4'b0111; step(1); expect_lit("fair_wrap_0", 7'b1_00_0001);
        req = 4'b0000; step(1);

        // Lone requester
        req = 4'b1000; step(1); expect_lit("lone_grant", 7'b1_11_1000);
        req = 4'b0000; step(1); expect_lit("lone_drop", 7'b0_11_0000);
        req = 4'b1000; step(1); expect_lit("lone_regrant", 7'b1_11_1000);
        req = 4'b0000; step(1);

        // Hold-time limit: owner 1 keeps requesting, client 2 waits
        req = 4'b0010; step(1); expect_lit("hold_c0", 7'b1_01_0010);
        req = 4'b0110; step(1); expect_lit("hold_c1", 7'b1_01_0010);
        step(1); expect_lit("hold_c2", 7'b1_01_0010);
        step(1); expect_lit("hold_c3", 7'b1_01_0010);
`ifdef RR_ARB_TIMEOUT_EN
        step(1); expect_lit("timeout_handoff", 7'b1_10_0100);
`else
        step(1); expect_lit("no_timeout_keep", 7'b1_01_0010);
`endif
        step(3);
        req = 4'b0000; step(1);

        // Reset in the middle of a grant
        req = 4'b0100; step(1); expect_lit("pre_rst_owner2", 7'b1_10_0100);
        rst = 1'b1; req = 4'b1111; step(1); expect_lit("rst_mid_grant", 7'b0_00_0000);
        rst = 1'b0; step(1); expect_lit("post_rst_grant0", 7'b1_00_0001);

        // Releasing owner 1 cannot re-win; client 3 takes over
        req = 4'b1110; step(1); expect_lit("simul_owner1", 7'b1_01_0010);
        req = 4'b1000; step(1); expect_lit("simul_next3", 7'b1_11_1000);
        req = 4'b1010; step(1); expect_lit("simul_keep3", 7'b1_11_1000);
        req = 4'b0000; step(2);

        chk_on = 1'b0;
        step(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
